// File: rtl/vga_pkg.sv
// Shared constants, lock-state encoding and colour classification for the VGA receive monitor.
package vga_pkg;

    localparam int          CW            = 16;
    localparam logic [15:0] NO_BAR        = 16'hFFFF;
    localparam logic [7:0]  COLOUR_THRESH = 8'h80;
    localparam int          NOM_H_TOTAL   = 1058;
    localparam int          NOM_V_TOTAL   = 627;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    function automatic logic is_red(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return (r >= COLOUR_THRESH) && (g < COLOUR_THRESH) && (b < COLOUR_THRESH);
    endfunction

    function automatic logic is_blue(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return (b >= COLOUR_THRESH) && (r < COLOUR_THRESH) && (g < COLOUR_THRESH);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and flags its falling edge for one cycle.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic fall
);

    logic sync_reg;
    logic sync_prev_reg;

    // Idle level is high so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg      <= 1'b1;
            sync_prev_reg <= 1'b1;
        end else begin
            sync_reg      <= sync;
            sync_prev_reg <= sync_reg;
        end
    end

    assign fall = sync_prev_reg & ~sync_reg;

endmodule

// File: rtl/vga_rx_monitor.sv
// Recovers line/frame timing from the bar-chart VGA stream, tracks lock and
// reports the top line of the red and blue bars seen at two probe columns.
module vga_rx_monitor #(
    parameter int PROBE_X1    = 450,
    parameter int PROBE_X2    = 850,
    parameter int LOCK_FRAMES = 3,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic [7:0]    vga_r,
    input  logic [7:0]    vga_g,
    input  logic [7:0]    vga_b,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          locked,
    output logic          sync_err,
    output logic          frame_done,
    output logic [CW-1:0] bar1_top,
    output logic [CW-1:0] bar2_top
);
    import vga_pkg::*;

    logic          hs_fall, vs_fall;
    logic [7:0]    r_reg, g_reg, b_reg;
    logic [CW-1:0] hcnt_reg, vcnt_reg, h_meas_reg, h_total_reg, v_total_reg;
    logic          frame_started_reg, frame_done_reg, sync_err_reg;
    logic          hcnt_sat, frame_end, same;
    logic [CW-1:0] line_len, line_cnt;
    lock_state_t   state_reg, state_next;
    logic [CW-1:0] ref_h_reg, ref_h_next, ref_v_reg, ref_v_next;
    logic [3:0]    match_reg, match_next;
    logic          sync_err_next;

    vga_sync_edge u_hs (.clk(clk), .rst(rst), .sync(vga_hs), .fall(hs_fall));
    vga_sync_edge u_vs (.clk(clk), .rst(rst), .sync(vga_vs), .fall(vs_fall));

    assign hcnt_sat  = &hcnt_reg;
    assign frame_end = vs_fall && frame_started_reg;
    // A coincident hs fall closes a line in the same cycle, so count it here.
    assign line_len  = hs_fall ? (hcnt_reg + CW'(1)) : h_meas_reg;
    assign line_cnt  = vcnt_reg + CW'(hs_fall);
    assign same      = (line_len == ref_h_reg) && (line_cnt == ref_v_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg             <= '0;
            g_reg             <= '0;
            b_reg             <= '0;
            hcnt_reg          <= '0;
            vcnt_reg          <= '0;
            h_meas_reg        <= '0;
            h_total_reg       <= '0;
            v_total_reg       <= '0;
            frame_started_reg <= 1'b0;
            frame_done_reg    <= 1'b0;
        end else begin
            r_reg          <= vga_r;
            g_reg          <= vga_g;
            b_reg          <= vga_b;
            frame_done_reg <= frame_end;
            if (hs_fall) begin
                hcnt_reg   <= '0;
                h_meas_reg <= hcnt_reg + CW'(1);
            end else if (!hcnt_sat) begin
                hcnt_reg <= hcnt_reg + CW'(1);
            end
            if (vs_fall) begin
                vcnt_reg <= '0;
            end else if (hs_fall && !(&vcnt_reg)) begin
                vcnt_reg <= vcnt_reg + CW'(1);
            end
            if (vs_fall) begin
                frame_started_reg <= 1'b1;
            end
            if (frame_end) begin
                h_total_reg <= line_len;
                v_total_reg <= line_cnt;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_bar
        localparam int PX = (gi == 0) ? PROBE_X1 : PROBE_X2;
        logic [CW-1:0] min_reg, top_reg;
        logic          colour, hit;

        assign colour = (gi == 0) ? is_red(r_reg, g_reg, b_reg) : is_blue(r_reg, g_reg, b_reg);
        assign hit    = colour && (hcnt_reg == CW'(PX)) && (vcnt_reg < min_reg);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                min_reg <= '1;
                top_reg <= '1;
            end else if (vs_fall) begin
                min_reg <= '1;
                if (frame_started_reg) begin
                    top_reg <= min_reg;
                end
            end else if (hit) begin
                min_reg <= vcnt_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= UNLOCKED;
            ref_h_reg    <= '0;
            ref_v_reg    <= '0;
            match_reg    <= '0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ref_h_reg    <= ref_h_next;
            ref_v_reg    <= ref_v_next;
            match_reg    <= match_next;
            sync_err_reg <= sync_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ref_h_next    = ref_h_reg;
        ref_v_next    = ref_v_reg;
        match_next    = match_reg;
        sync_err_next = 1'b0;
        if (hcnt_sat) begin
            // hsync has vanished: drop lock without waiting for a frame end.
            state_next    = UNLOCKED;
            sync_err_next = (state_reg == LOCKED);
        end else if (frame_end) begin
            case (state_reg)
                UNLOCKED: begin
                    ref_h_next = line_len;
                    ref_v_next = line_cnt;
                    match_next = 4'd1;
                    state_next = CHECK;
                end
                CHECK: begin
                    if (same) begin
                        match_next = match_reg + 4'd1;
                        if ((int'(match_reg) + 1) >= LOCK_FRAMES) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        ref_h_next = line_len;
                        ref_v_next = line_cnt;
                        match_next = 4'd1;
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        sync_err_next = 1'b1;
                        state_next    = UNLOCKED;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    assign h_total    = h_total_reg;
    assign v_total    = v_total_reg;
    assign locked     = (state_reg == LOCKED);
    assign sync_err   = sync_err_reg;
    assign frame_done = frame_done_reg;
    assign bar1_top   = g_bar[0].top_reg;
    assign bar2_top   = g_bar[1].top_reg;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 36/40 x 30 raster so every
// scenario, including the hsync watchdog, fits in a short run.
module tb_vga_rx_monitor;

    localparam int CW   = 10;
    localparam int PX1  = 12;
    localparam int PX2  = 28;
    localparam int NONE = 1023;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vga_hs = 1'b1;
    logic          vga_vs = 1'b1;
    logic [7:0]    vga_r = 8'h00;
    logic [7:0]    vga_g = 8'h00;
    logic [7:0]    vga_b = 8'h00;
    logic [CW-1:0] h_total, v_total, bar1_top, bar2_top;
    logic          locked, sync_err, frame_done;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    int se_cnt   = 0;
    int fd0      = 0;
    int se0      = 0;

    vga_rx_monitor #(
        .PROBE_X1(PX1), .PROBE_X2(PX2), .LOCK_FRAMES(3), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .h_total(h_total), .v_total(v_total),
        .locked(locked), .sync_err(sync_err), .frame_done(frame_done),
        .bar1_top(bar1_top), .bar2_top(bar2_top)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (sync_err) se_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One raster frame; vs is low for two lines starting voff clocks into line 0.
    task automatic gen_frame(input int hlen, input int vlen, input int r_top, input int b_top, input int voff);
        for (int y = 0; y < vlen; y++) begin
            for (int x = 0; x < hlen; x++) begin
                int p;
                @(negedge clk);
                p = y * hlen + x;
                vga_hs = (x >= 4);
                vga_vs = !((p >= voff) && (p < voff + 2 * hlen));
                {vga_r, vga_g, vga_b} = 24'h000000;
                if (y == 1) {vga_r, vga_g, vga_b} = 24'h00FF00;
                if (x >= 10 && x <= 16) begin
                    if (y == 2) {vga_r, vga_g, vga_b} = 24'hFFFF00;
                    if (y == 3) {vga_r, vga_g, vga_b} = 24'h7F0000;
                    if (y >= r_top) {vga_r, vga_g, vga_b} = 24'h807F7F;
                end
                if (x >= 26 && x <= 32) begin
                    if (y == 2) {vga_r, vga_g, vga_b} = 24'hFFFFFF;
                    if (y == 3) {vga_r, vga_g, vga_b} = 24'h00007F;
                    if (y >= b_top) {vga_r, vga_g, vga_b} = 24'h7F7F80;
                end
            end
        end
    endtask

    task automatic check_reset_values(input string phase);
        check({phase, "_h_total"}, 32'(h_total), 0);
        check({phase, "_v_total"}, 32'(v_total), 0);
        check({phase, "_bar1"}, 32'(bar1_top), NONE);
        check({phase, "_bar2"}, 32'(bar2_top), NONE);
        check({phase, "_locked"}, 32'(locked), 0);
        check({phase, "_sync_err"}, 32'(sync_err), 0);
        check({phase, "_frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Nominal raster with both bars: lock on the 4th vs fall.
        gen_frame(40, 30, 5, 12, 0); #2;
        check("first_vs_no_done", 32'(fd_cnt), 0);
        check("first_vs_no_update", 32'(v_total), 0);
        gen_frame(40, 30, 5, 12, 0); #2;
        check("h_total", 32'(h_total), 40);
        check("v_total", 32'(v_total), 30);
        check("bar1_top", 32'(bar1_top), 5);
        check("bar2_top", 32'(bar2_top), 12);
        check("frame_done_1", 32'(fd_cnt), 1);
        check("locked_vs2", 32'(locked), 0);
        gen_frame(40, 30, 5, 12, 0); #2;
        check("locked_vs3", 32'(locked), 0);
        gen_frame(40, 30, 5, 12, 0); #2;
        check("locked_vs4", 32'(locked), 1);
        check("frame_done_3", 32'(fd_cnt), 3);

        // No bars drawn.
        gen_frame(40, 30, 30, 30, 0);
        gen_frame(40, 30, 30, 30, 0); #2;
        check("nobar1", 32'(bar1_top), NONE);
        check("nobar2", 32'(bar2_top), NONE);
        check("nobar_locked", 32'(locked), 1);

        // Line length change while locked, then relock.
        se0 = se_cnt;
        gen_frame(36, 30, 5, 12, 0);
        gen_frame(36, 30, 5, 12, 0); #2;
        check("chg_sync_err", se_cnt - se0, 1);
        check("chg_locked", 32'(locked), 0);
        check("chg_h_total", 32'(h_total), 36);
        gen_frame(36, 30, 5, 12, 0); #2;
        check("relock_1", 32'(locked), 0);
        gen_frame(36, 30, 5, 12, 0); #2;
        check("relock_2", 32'(locked), 0);
        gen_frame(36, 30, 5, 12, 0); #2;
        check("relock_3", 32'(locked), 1);
        check("relock_sync_err", se_cnt - se0, 1);

        // vs fall offset from and aligned with hs fall; red from line 0.
        gen_frame(36, 30, 0, 12, 5);
        gen_frame(36, 30, 0, 12, 5); #2;
        check("off_v_total", 32'(v_total), 30);
        check("off_bar1", 32'(bar1_top), 0);
        check("off_h_total", 32'(h_total), 36);
        check("off_locked", 32'(locked), 1);
        gen_frame(36, 30, 0, 12, 0);
        gen_frame(36, 30, 0, 12, 0); #2;
        check("align_v_total", 32'(v_total), 30);
        check("align_bar1", 32'(bar1_top), 0);
        check("align_bar2", 32'(bar2_top), 12);
        check("align_locked", 32'(locked), 1);

        // hsync stops: watchdog fires once hcnt saturates at 1023.
        se0 = se_cnt;
        @(negedge clk);
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        {vga_r, vga_g, vga_b} = 24'h000000;
        repeat (900) @(negedge clk);
        #2;
        check("wdog_before", 32'(locked), 1);
        check("wdog_before_err", se_cnt - se0, 0);
        repeat (200) @(negedge clk);
        #2;
        check("wdog_locked", 32'(locked), 0);
        check("wdog_sync_err", se_cnt - se0, 1);

        // Mid-frame reset.
        gen_frame(36, 30, 5, 12, 0);
        gen_frame(36, 30, 5, 12, 0);
        gen_frame(36, 15, 5, 12, 0); #2;
        check("pre_reset_bar1", 32'(bar1_top), 5);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fd0 = fd_cnt;
        gen_frame(36, 30, 5, 12, 0); #2;
        check("rst_vs1_done", fd_cnt - fd0, 0);
        check("rst_vs1_v_total", 32'(v_total), 0);
        gen_frame(36, 30, 5, 12, 0); #2;
        check("rst_vs2_done", fd_cnt - fd0, 1);
        check("rst_vs2_v_total", 32'(v_total), 30);
        check("rst_vs2_bar1", 32'(bar1_top), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
